control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL have port: clr  input  1  reset, asynchronous, active-low (clr=0 resets).
REQ-003 SHALL have port: ir  input  32  instruction register contents: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-004 SHALL have port: mem_ready  input  1  memory completes current Read/Write this cycle.
REQ-005 SHALL have ports: Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-select controls to the select/encode logic.
REQ-006 SHALL have ports: PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, Read, Write  output  1 each  datapath strobes.
REQ-007 SHALL have ports: alu_op  output  5  ALU operation code; run  output  1  high while not halted.

Function
REQ-008 SHALL be a Moore FSM: every output decoded from the current state register only; unlisted outputs are 0 in each state.
REQ-009 SHALL implement states RESET, FETCH0, FETCH1, FETCH2, DECODE, T3, T4, T5, T6, T7, HALTED.
REQ-010 RESET: all outputs 0 except run=1; next state FETCH0.
REQ-011 FETCH0: PCout, MARin, IncPC, Zin; -> FETCH1.
REQ-012 FETCH1: Zlowout, PCin, Read, MDRin; PCin asserted only on the first FETCH1 cycle; stay while mem_ready=0, -> FETCH2 when mem_ready=1.
REQ-013 FETCH2: MDRout, IRin; -> DECODE.
REQ-014 DECODE: no strobes; branches on ir[31:27], latched into an internal 5-bit opcode register on this edge.
REQ-015 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, nop 11010, halt 11011; any other value SHALL behave as nop.
REQ-016 R-type (add/sub/and/or): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, alu_op=opcode; T5 Zlowout,Gra,Rin; -> FETCH0.
REQ-017 Immediate (addi/andi/ori): T3 Grb,Rout,Yin; T4 Cout,Zin, alu_op = 00011/00101/00110 respectively; T5 Zlowout,Gra,Rin; -> FETCH0.
REQ-018 ldi: T3 Grb,BAout,Yin; T4 Cout,Zin,alu_op=00011; T5 Zlowout,Gra,Rin; -> FETCH0.
REQ-019 ld: T3/T4 as ldi; T5 Zlowout,MARin; T6 Read,MDRin, held until mem_ready=1; T7 MDRout,Gra,Rin; -> FETCH0.
REQ-020 st: T3/T4 as ldi; T5 Zlowout,MARin; T6 Gra,Rout,MDRin (Read=0, MDR loads from bus); T7 Write, held until mem_ready=1; -> FETCH0.
REQ-021 nop/unknown: DECODE -> FETCH0 directly.
REQ-022 halt: DECODE -> HALTED; HALTED drives run=0, all strobes 0, and is left only by reset.
REQ-023 alu_op SHALL be 00000 in every state other than T4; Rout and BAout SHALL never be asserted together.
REQ-024 mem_ready SHALL be ignored in all states except FETCH1, ld-T6, st-T7.
REQ-025 ir SHALL be sampled only in DECODE; changes to ir in other states SHALL not affect sequencing.
REQ-026 Latency with mem_ready=1: R-type/immediate/ldi 7 cycles FETCH0-to-FETCH0; ld/st 9 cycles; nop 4 cycles.

Reset
REQ-027 clr=0 SHALL force state RESET and opcode register 00000 immediately, independent of clk, in any state including mid-wait in FETCH1/T6/T7.
REQ-028 While clr=0 all outputs SHALL equal the RESET state values (run=1, strobes 0); first rising edge with clr=1 enters FETCH0.

Verification
REQ-029 Reset release, mem_ready=1, ir=32'h19890000 (add R3,R1,R2) -> FETCH0..T5 in 7 cycles; T4 Grc=1,Rout=1,alu_op=00011; T5 Gra=1,Rin=1; then FETCH0.
REQ-030 mem_ready=0 for 3 cycles in FETCH1 -> Read/MDRin high 4 cycles, PCin high only first cycle, then FETCH2.
REQ-031 ir=32'h00800000 (ld R1), mem_ready low 2 cycles in T6 -> T6 lasts 3 cycles; T7 MDRout=1,Gra=1,Rin=1; 11 cycles total.
REQ-032 ir=32'h10800000 (st R1) -> T6 Gra,Rout,MDRin with Read=0; T7 Write=1 until mem_ready; never Rin.
REQ-033 ir=32'hD8000000 (halt) -> HALTED after DECODE, run=0, strobes 0 for 20 cycles; clr pulse low -> run=1, FETCH0 on next edge.
REQ-034 clr asserted mid-T4 of addi -> outputs drop to RESET values without a clock edge; alu_op=00000.

Source files
------------

// File: rtl/control_sequencer.sv
// Control sequencer for a simple multi-cycle datapath.
// Moore FSM: fetch, decode, then up to five execute steps (T3..T7).
// Outputs are decoded from registered state only (state, latched opcode,
// and a one-bit flag that limits PCin to the first FETCH1 cycle).
//
// state   | meaning
// --------+----------------------------------------------------------
// RESET   | held while clr=0; run=1, all strobes 0
// FETCH0  | PC -> MAR, PC+1 -> Z
// FETCH1  | Z -> PC (first cycle only), memory read into MDR, wait
// FETCH2  | MDR -> IR
// DECODE  | opcode latched from ir, branch by instruction class
// T3      | operand B (or base/zero) -> Y
// T4      | ALU operation -> Z
// T5      | Z -> Ra, or Z -> MAR for ld/st
// T6      | ld: memory read into MDR (wait); st: Ra -> MDR
// T7      | ld: MDR -> Ra; st: memory write (wait)
// HALTED  | run=0, left only by reset
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_HALT
  } iclass_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state, state_nxt;
  logic [4:0] opcode;
  logic       pcin_done;
  iclass_t    cls_dec;
  iclass_t    cls_cur;

  // Register fields are consumed by the select/encode logic, not here.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  // Unlisted opcodes (including nop) fall through to C_NOP.
  function automatic iclass_t classify(input logic [4:0] op);
    case (op)
      OP_LD:                          classify = C_LD;
      OP_LDI:                         classify = C_LDI;
      OP_ST:                          classify = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  classify = C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       classify = C_IMM;
      OP_HALT:                        classify = C_HALT;
      default:                        classify = C_NOP;
    endcase
  endfunction

  assign cls_dec = classify(ir[31:27]);
  assign cls_cur = classify(opcode);

  // State, opcode latch and first-FETCH1-cycle flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_RESET;
      opcode    <= 5'b00000;
      pcin_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      pcin_done <= (state == S_FETCH1);
      if (state == S_DECODE) opcode <= ir[31:27];
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_nxt = state;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    Cout = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_op = 5'b00000;
    run = 1'b1;
    case (state)
      S_RESET: state_nxt = S_FETCH0;
      S_FETCH0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_nxt = S_FETCH1;
      end
      S_FETCH1: begin
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin = !pcin_done;
        if (mem_ready) state_nxt = S_FETCH2;
      end
      S_FETCH2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (cls_dec)
          C_NOP:   state_nxt = S_FETCH0;
          C_HALT:  state_nxt = S_HALTED;
          default: state_nxt = S_T3;
        endcase
      end
      S_T3: begin
        Grb = 1'b1; Yin = 1'b1;
        // Base-address form forces zero when Rb is R0; only for address/ldi.
        if (cls_cur == C_LDI || cls_cur == C_LD || cls_cur == C_ST) BAout = 1'b1;
        else                                                       Rout  = 1'b1;
        state_nxt = S_T4;
      end
      S_T4: begin
        Zin = 1'b1;
        if (cls_cur == C_RTYPE) begin
          Grc = 1'b1; Rout = 1'b1; alu_op = opcode;
        end else begin
          Cout = 1'b1;
          case (opcode)
            OP_ANDI: alu_op = OP_AND;
            OP_ORI:  alu_op = OP_OR;
            default: alu_op = OP_ADD;
          endcase
        end
        state_nxt = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls_cur == C_LD || cls_cur == C_ST) begin
          MARin = 1'b1;
          state_nxt = S_T6;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
          state_nxt = S_FETCH0;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (cls_cur == C_ST) begin
          Gra = 1'b1; Rout = 1'b1;
          state_nxt = S_T7;
        end else begin
          Read = 1'b1;
          if (mem_ready) state_nxt = S_T7;
        end
      end
      S_T7: begin
        if (cls_cur == C_ST) begin
          Write = 1'b1;
          if (mem_ready) state_nxt = S_FETCH0;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          state_nxt = S_FETCH0;
        end
      end
      S_HALTED: run = 1'b0;
      default:  state_nxt = S_RESET;
    endcase
  end

endmodule
